// File: rtl/srec_word_writer.sv
// Packs the S-record parser's byte write stream into word-aligned 32-bit writes
// with byte enables, buffered by a small FIFO so memory stalls never stall the parser.
module srec_word_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] byte_address,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  input  logic        flush,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_write,
  input  logic        mem_ready,
  output logic        overflow,
  output logic        busy,
  output logic [15:0] words_written
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  // Accumulator and pending-flush state
  logic        acc_valid_q, acc_valid_d;
  logic [29:0] acc_addr_q, acc_addr_d;
  logic [31:0] acc_data_q, acc_data_d;
  logic [3:0]  acc_be_q, acc_be_d;
  logic        pend_q, pend_d;

  // FIFO state
  logic [29:0]   fifo_addr [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [3:0]    fifo_be   [FIFO_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          busy_q;
  logic [15:0]   words_q;

  logic [1:0]  lane;
  logic [3:0]  lane_be;
  logic [31:0] lane_data;
  logic [31:0] lane_mask;
  logic [31:0] merged_data;
  logic [3:0]  merged_be;
  logic        same_word;

  logic        push;
  logic [29:0] push_addr;
  logic [31:0] push_data;
  logic [3:0]  push_be;
  logic        pop;
  logic        full;
  logic        do_write;

  // Big-endian lane is 3 - address[1:0], which for two bits is the inversion.
  assign lane        = BIG_ENDIAN ? ~byte_address[1:0] : byte_address[1:0];
  assign lane_be     = 4'b0001 << lane;
  assign lane_data   = {24'd0, byte_data} << {lane, 3'b000};
  assign lane_mask   = {{8{lane_be[3]}}, {8{lane_be[2]}}, {8{lane_be[1]}}, {8{lane_be[0]}}};
  assign merged_data = (acc_data_q & ~lane_mask) | lane_data;
  assign merged_be   = acc_be_q | lane_be;
  assign same_word   = acc_valid_q && (byte_address[31:2] == acc_addr_q);

  always_comb begin
    acc_valid_d = acc_valid_q;
    acc_addr_d  = acc_addr_q;
    acc_data_d  = acc_data_q;
    acc_be_d    = acc_be_q;
    pend_d      = pend_q;
    push        = 1'b0;
    push_addr   = acc_addr_q;
    push_data   = acc_data_q;
    push_be     = acc_be_q;
    if (byte_valid) begin
      // A byte always wins; any flush request keeps deferring behind it.
      pend_d = flush | pend_q;
      if (same_word) begin
        if (merged_be == 4'hF) begin
          push        = 1'b1;
          push_data   = merged_data;
          push_be     = merged_be;
          acc_valid_d = 1'b0;
          acc_data_d  = 32'd0;
          acc_be_d    = 4'd0;
        end else begin
          acc_data_d = merged_data;
          acc_be_d   = merged_be;
        end
      end else begin
        push        = acc_valid_q;
        acc_valid_d = 1'b1;
        acc_addr_d  = byte_address[31:2];
        acc_data_d  = lane_data;
        acc_be_d    = lane_be;
      end
    end else if (flush || pend_q) begin
      pend_d      = 1'b0;
      push        = acc_valid_q;
      acc_valid_d = 1'b0;
      acc_data_d  = 32'd0;
      acc_be_d    = 4'd0;
    end
  end

  assign pop      = (count_q != '0) && mem_ready;
  assign full     = (count_q == FULL_COUNT);
  assign do_write = push && (!full || pop);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push && full && !pop);
    if (pop) head_d = head_q + 1'b1;
    if (do_write) tail_d = tail_q + 1'b1;
    if (do_write && !pop) count_d = count_q + 1'b1;
    else if (!do_write && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_valid_q <= 1'b0;
      acc_addr_q  <= 30'd0;
      acc_data_q  <= 32'd0;
      acc_be_q    <= 4'd0;
      pend_q      <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      words_q     <= 16'd0;
    end else begin
      acc_valid_q <= acc_valid_d;
      acc_addr_q  <= acc_addr_d;
      acc_data_q  <= acc_data_d;
      acc_be_q    <= acc_be_d;
      pend_q      <= pend_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      busy_q      <= acc_valid_d | pend_d | (count_d != '0);
      if (pop) words_q <= words_q + 16'd1;
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clock) begin
    if (do_write) begin
      fifo_addr[tail_q] <= push_addr;
      fifo_data[tail_q] <= push_data;
      fifo_be[tail_q]   <= push_be;
    end
  end

  assign mem_write       = (count_q != '0);
  assign mem_address     = mem_write ? {fifo_addr[head_q], 2'b00} : 32'd0;
  assign mem_data        = mem_write ? fifo_data[head_q] : 32'd0;
  assign mem_byte_enable = mem_write ? fifo_be[head_q] : 4'd0;
  assign overflow        = overflow_q;
  assign busy            = busy_q;
  assign words_written   = words_q;

endmodule
